// File: rtl/straight_eval_scheduler_if.sv
// Bundle of request, detector and result signals for straight_eval_scheduler.
//   master : requester/detector/consumer side (drives req, hand, det_*, res_ready)
//   slave  : the scheduler itself (drives ack, det_rank*, res_*, straight_cnt, busy)
// Hand layout: hand[20i+4k+3 : 20i+4k] is rank k of requester i.
interface straight_eval_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*20-1:0] hand;
  logic [NUM_REQ-1:0]    ack;
  logic [3:0]            det_rank0;
  logic [3:0]            det_rank1;
  logic [3:0]            det_rank2;
  logic [3:0]            det_rank3;
  logic [3:0]            det_rank4;
  logic                  det_straight;
  logic [9:0]            det_kind;
  logic                  res_valid;
  logic                  res_ready;
  logic [ID_W-1:0]       res_id;
  logic                  res_straight;
  logic [3:0]            res_high;
  logic                  res_error;
  logic [CNT_W-1:0]      straight_cnt;
  logic                  busy;

  modport master (
    output req, hand, det_straight, det_kind, res_ready,
    input  ack, det_rank0, det_rank1, det_rank2, det_rank3, det_rank4,
    input  res_valid, res_id, res_straight, res_high, res_error, straight_cnt, busy
  );

  modport slave (
    input  req, hand, det_straight, det_kind, res_ready,
    output ack, det_rank0, det_rank1, det_rank2, det_rank3, det_rank4,
    output res_valid, res_id, res_straight, res_high, res_error, straight_cnt, busy
  );
endinterface

// File: rtl/straight_eval_scheduler.sv
// Shares one external combinational straight detector among NUM_REQ requesters.
// A round-robin arbiter picks one pending hand, registers its ranks onto the
// detector inputs, waits DET_LAT cycles, then presents a tagged result through
// a valid/ready port and counts accepted straights (saturating).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of straight_eval_scheduler_if (req/hand/ack,
//            det_rank0..4/det_straight/det_kind, res_*, straight_cnt, busy)
module straight_eval_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DET_LAT = 1,
  parameter int CNT_W   = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  straight_eval_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  logic [ID_W-1:0]   ptr_r;
  logic [2:0]        lat_r;
  logic [3:0]        det_rank0_r;
  logic [3:0]        det_rank1_r;
  logic [3:0]        det_rank2_r;
  logic [3:0]        det_rank3_r;
  logic [3:0]        det_rank4_r;
  logic              res_valid_r;
  logic [ID_W-1:0]   res_id_r;
  logic              res_straight_r;
  logic [3:0]        res_high_r;
  logic              res_error_r;
  logic [CNT_W-1:0]  straight_cnt_r;
  logic              busy_r;

  logic [19:0]       hand_arr_s [NUM_REQ];
  logic [ID_W:0]     sum_s;
  logic [ID_W-1:0]   idx_s;
  logic              found_s;
  logic [ID_W-1:0]   grant_id_s;
  logic [19:0]       grant_hand_s;
  logic [ID_W-1:0]   ptr_next_s;
  logic [NUM_REQ-1:0] ack_s;
  logic              rank_bad_s;
  logic              err_s;
  logic              str_s;
  logic [3:0]        high_s;

  // Ranks 0, 14 and 15 do not exist in the A..K encoding.
  function automatic logic rank_illegal(input logic [3:0] r);
    return (r == 4'd0) || (r >= 4'd14);
  endfunction

  // True when at most one straight-kind bit is set.
  function automatic logic kind_onehot0(input logic [9:0] k);
    return (k & (k - 10'd1)) == 10'd0;
  endfunction

  // Kind bit b means the straight tops out at rank b+5 (bit9 -> 14, ace high).
  function automatic logic [3:0] kind_high(input logic [9:0] k);
    logic [3:0] h;
    h = 4'd0;
    for (int b = 0; b < 10; b++) begin
      h = k[b] ? 4'(b + 5) : h;
    end
    return h;
  endfunction

  // Unpack the flat hand bus into one 20-bit hand per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hand
    assign hand_arr_s[gi] = bus.hand[20*gi +: 20];
  end

  // Rotating-priority pick: scan from lowest to highest priority so the
  // last hit (closest at-or-after ptr) wins.
  always_comb begin
    found_s      = 1'b0;
    grant_id_s   = '0;
    grant_hand_s = 20'd0;
    sum_s        = '0;
    idx_s        = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum_s        = {1'b0, ptr_r} + (ID_W+1)'(i);
      idx_s        = (sum_s >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum_s - (ID_W+1)'(NUM_REQ))
                                                   : sum_s[ID_W-1:0];
      found_s      = found_s | bus.req[idx_s];
      grant_id_s   = bus.req[idx_s] ? idx_s : grant_id_s;
      grant_hand_s = bus.req[idx_s] ? hand_arr_s[idx_s] : grant_hand_s;
    end
  end

  // Pointer moves one past the winner, wrapping at NUM_REQ.
  always_comb begin
    if (grant_id_s == ID_W'(NUM_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_id_s + ID_W'(1);
    end
  end

  // ack is combinational on req so a request dropped in the grant cycle is
  // never acknowledged; gated by rst_n so every output reads 0 in reset.
  always_comb begin
    if ((state_r == ST_IDLE) && found_s && rst_n) begin
      ack_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_s;
    end else begin
      ack_s = '0;
    end
  end

  // Result qualification: reject illegal ranks and an incoherent detector.
  always_comb begin
    rank_bad_s = rank_illegal(det_rank0_r) | rank_illegal(det_rank1_r) |
                 rank_illegal(det_rank2_r) | rank_illegal(det_rank3_r) |
                 rank_illegal(det_rank4_r);
    err_s      = rank_bad_s | (bus.det_straight != (|bus.det_kind)) |
                 ~kind_onehot0(bus.det_kind);
    str_s      = bus.det_straight & ~err_s;
    if (str_s) begin
      high_s = kind_high(bus.det_kind);
    end else begin
      high_s = 4'd0;
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      ptr_r          <= '0;
      lat_r          <= 3'd0;
      det_rank0_r    <= 4'd0;
      det_rank1_r    <= 4'd0;
      det_rank2_r    <= 4'd0;
      det_rank3_r    <= 4'd0;
      det_rank4_r    <= 4'd0;
      res_valid_r    <= 1'b0;
      res_id_r       <= '0;
      res_straight_r <= 1'b0;
      res_high_r     <= 4'd0;
      res_error_r    <= 1'b0;
      straight_cnt_r <= '0;
      busy_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            det_rank0_r <= grant_hand_s[3:0];
            det_rank1_r <= grant_hand_s[7:4];
            det_rank2_r <= grant_hand_s[11:8];
            det_rank3_r <= grant_hand_s[15:12];
            det_rank4_r <= grant_hand_s[19:16];
            res_id_r    <= grant_id_s;
            ptr_r       <= ptr_next_s;
            lat_r       <= 3'd0;
            busy_r      <= 1'b1;
            state_r     <= ST_EVAL;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EVAL: begin
          // Detector outputs are trusted only after DET_LAT cycles of stable ranks.
          if (lat_r == 3'(DET_LAT - 1)) begin
            res_straight_r <= str_s;
            res_high_r     <= high_s;
            res_error_r    <= err_s;
            res_valid_r    <= 1'b1;
            state_r        <= ST_RESP;
          end else begin
            lat_r <= lat_r + 3'd1;
          end
        end
        ST_RESP: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
            if (res_straight_r && (straight_cnt_r != {CNT_W{1'b1}})) begin
              straight_cnt_r <= straight_cnt_r + CNT_W'(1);
            end else begin
              straight_cnt_r <= straight_cnt_r;
            end
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack          = ack_s;
  assign bus.det_rank0    = det_rank0_r;
  assign bus.det_rank1    = det_rank1_r;
  assign bus.det_rank2    = det_rank2_r;
  assign bus.det_rank3    = det_rank3_r;
  assign bus.det_rank4    = det_rank4_r;
  assign bus.res_valid    = res_valid_r;
  assign bus.res_id       = res_id_r;
  assign bus.res_straight = res_straight_r;
  assign bus.res_high     = res_high_r;
  assign bus.res_error    = res_error_r;
  assign bus.straight_cnt = straight_cnt_r;
  assign bus.busy         = busy_r;

endmodule
